// File: rtl/operand_sequencer.sv
// Operand sequencer: captures P then Q from switches on load edges, or sweeps
// the 10-bit pair {P,Q} through all values at one step per STEP_DIV cycles.
module operand_sequencer #(
   parameter int unsigned STEP_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] sw,
   input  logic       load,
   input  logic       sweep,
   output logic [4:0] P,
   output logic [4:0] Q,
   output logic       valid,
   output logic [1:0] state,
   output logic       done
);

   typedef enum logic [1:0] {
      S_P     = 2'd0,
      S_Q     = 2'd1,
      S_HOLD  = 2'd2,
      S_SWEEP = 2'd3
   } state_t;

   localparam logic [15:0] DIV_MAX = 16'(STEP_DIV - 1);

   state_t      r_state;
   logic [4:0]  r_p;
   logic [4:0]  r_q;
   logic        r_valid;
   logic        r_done;
   logic [15:0] r_div;
   logic        r_load_d;

   logic        w_load_edge;
   logic [9:0]  w_pair_next;

   assign w_load_edge = load & ~r_load_d;
   assign w_pair_next = {r_p, r_q} + 10'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_P;
         r_p      <= '0;
         r_q      <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_div    <= '0;
         r_load_d <= 1'b1;   // load already high at release must not count
      end else begin
         r_load_d <= load;
         r_done   <= 1'b0;
         if (r_state == S_SWEEP) begin
            if (!sweep) begin
               r_state <= S_P;
               r_valid <= 1'b0;
               r_div   <= '0;
            end else if (r_div == DIV_MAX) begin
               r_div          <= '0;
               {r_p, r_q}     <= w_pair_next;
               r_done         <= ({r_p, r_q} == 10'h3FF);
            end else begin
               r_div <= r_div + 16'd1;
            end
         end else if (sweep) begin
            // sweep entry wins over any same-cycle load edge
            r_state <= S_SWEEP;
            r_p     <= '0;
            r_q     <= '0;
            r_div   <= '0;
            r_valid <= 1'b1;
         end else if (w_load_edge) begin
            case (r_state)
               S_P: begin
                  r_p     <= sw;
                  r_state <= S_Q;
               end
               S_Q: begin
                  r_q     <= sw;
                  r_valid <= 1'b1;
                  r_state <= S_HOLD;
               end
               default: begin
                  r_p     <= sw;
                  r_valid <= 1'b0;
                  r_state <= S_Q;
               end
            endcase
         end
      end
   end

   assign P     = r_p;
   assign Q     = r_q;
   assign valid = r_valid;
   assign state = r_state;
   assign done  = r_done;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed scenarios plus random traffic, all
// checked each cycle against a mode/elapsed-time model of the sequencer.
module tb_operand_sequencer;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] sw;
   logic       load;
   logic       sweep;
   logic [4:0] P, Q, P1, Q1;
   logic       valid, done, valid1, done1;
   logic [1:0] state, state1;

   operand_sequencer #(.STEP_DIV(SD)) u_dut (
      .clk(clk), .rst(rst), .sw(sw), .load(load), .sweep(sweep),
      .P(P), .Q(Q), .valid(valid), .state(state), .done(done)
   );

   operand_sequencer #(.STEP_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .sw(sw), .load(load), .sweep(sweep),
      .P(P1), .Q(Q1), .valid(valid1), .state(state1), .done(done1)
   );

   always #5 clk = ~clk;

   int n_tot  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Model: mode 0=await P, 1=await Q, 2=hold, 3=sweep. In sweep the pair is
   // simply (cycles since entry / SD) mod 1024.
   int         m_mode;
   int         m_n;
   logic [4:0] m_p, m_q;
   logic       m_valid, m_done, m_prev_load;
   logic       m_checking = 1'b0;

   always @(posedge clk) begin
      logic       edge_seen;
      logic [9:0] pair;
      if (rst) begin
         m_mode = 0; m_n = 0; m_p = 0; m_q = 0;
         m_valid = 0; m_done = 0; m_prev_load = 1;
         m_checking = 1'b1;
      end else begin
         edge_seen   = load && !m_prev_load;
         m_prev_load = load;
         m_done      = 0;
         if (m_mode == 3) begin
            if (!sweep) begin
               m_mode = 0; m_valid = 0;
            end else begin
               m_n++;
               if (m_n % SD == 0) begin
                  pair   = 10'((m_n / SD) % 1024);
                  m_p    = pair[9:5];
                  m_q    = pair[4:0];
                  m_done = (pair == 10'd0);
               end
            end
         end else if (sweep) begin
            m_mode = 3; m_n = 0; m_p = 0; m_q = 0; m_valid = 1;
         end else if (edge_seen) begin
            if (m_mode == 0)      begin m_p = sw; m_mode = 1; end
            else if (m_mode == 1) begin m_q = sw; m_valid = 1; m_mode = 2; end
            else                  begin m_p = sw; m_valid = 0; m_mode = 1; end
         end
      end
   end

   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (m_checking) begin
         chk("P", P, m_p);
         chk("Q", Q, m_q);
         chk("valid", valid, m_valid);
         chk("state", state, m_mode);
         chk("done", done, m_done);
         chk("done_twice", int'(done && prev_done), 0);
         prev_done = done;
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int done_cnt, done1_cnt;
      rst = 1; sw = 0; load = 0; sweep = 0;
      cyc(2);
      rst = 0;
      cyc();
      chk("rst_P", P, 0); chk("rst_state", state, 0); chk("rst_valid", valid, 0);

      // Manual load of P=12, Q=7
      sw = 5'd12; load = 1; cyc();
      chk("ld1_P", P, 12); chk("ld1_valid", valid, 0); chk("ld1_state", state, 1);
      load = 0; cyc();
      sw = 5'd7; load = 1; cyc();
      chk("ld2_Q", Q, 7); chk("ld2_valid", valid, 1); chk("ld2_state", state, 2);
      load = 0; cyc();

      // Reload from hold with load held high for 10 cycles
      sw = 5'd20; load = 1; cyc(10);
      chk("rl_P", P, 20); chk("rl_Q", Q, 7); chk("rl_valid", valid, 0); chk("rl_state", state, 1);
      load = 0; cyc();

      // Sweep entry with a coincident load edge, then exit at 0x025
      sw = 5'd9; load = 1; sweep = 1; cyc();
      chk("sw_P", P, 0); chk("sw_Q", Q, 0); chk("sw_valid", valid, 1); chk("sw_state", state, 3);
      load = 0;
      cyc(37 * SD);
      chk("sw_pair25", {P, Q}, 10'h025);
      sweep = 0; cyc();
      chk("ex_P", P, 1); chk("ex_Q", Q, 5); chk("ex_state", state, 0); chk("ex_valid", valid, 0);
      cyc();

      // Full sweep; the STEP_DIV=1 instance steps every cycle alongside
      sweep = 1; cyc();
      chk("fs1_pair0", {P1, Q1}, 0);
      done_cnt = 0; done1_cnt = 0;
      for (int j = 1; j <= 1024 * SD; j++) begin
         cyc();
         if (done)  done_cnt++;
         if (done1) done1_cnt++;
         chk("fs1_pair", {P1, Q1}, j % 1024);
      end
      chk("fs_pair_end", {P, Q}, 0);
      chk("fs_done_cnt", done_cnt, 1);
      chk("fs1_done_cnt", done1_cnt, SD);
      sweep = 0; cyc();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         sw   = 5'($urandom);
         load = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) sweep = ~sweep;
         rst  = ($urandom_range(0, 63) == 0);
         cyc();
      end
      rst = 0; load = 0; sweep = 0; cyc(2);

      // Reset mid-sweep, then load held high across reset release
      sweep = 1; cyc(9);
      rst = 1; sweep = 0; cyc();
      chk("rc_P", P, 0); chk("rc_Q", Q, 0); chk("rc_valid", valid, 0);
      chk("rc_state", state, 0); chk("rc_done", done, 0);
      load = 1; sw = 5'd17; cyc();
      rst = 0; cyc(4);
      chk("rc_hold_P", P, 0); chk("rc_hold_state", state, 0);
      load = 0; cyc(2);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter STEP_DIV, default 4: clock cycles per sweep step, legal range 1..65535.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-004 SHALL have port sw, input, 5: operand value from switches, already synchronous to clk.
REQ-005 SHALL have port load, input, 1: load pushbutton, level-sensitive, already synchronous.
REQ-006 SHALL have port sweep, input, 1: sweep mode select, level-sensitive.
REQ-007 SHALL have port P, output, 5: registered first operand for the downstream combinational stage.
REQ-008 SHALL have port Q, output, 5: registered second operand for the downstream combinational stage.
REQ-009 SHALL have port valid, output, 1: high when P and Q form a complete, stable operand pair.
REQ-010 SHALL have port state, output, 2: current FSM state code.
REQ-011 SHALL have port done, output, 1: one-cycle pulse marking completion of a full sweep.

Function
REQ-012 SHALL encode FSM states as S_P=2'd0 (await P), S_Q=2'd1 (await Q), S_HOLD=2'd2 (pair held), S_SWEEP=2'd3; state output = current state.
REQ-013 SHALL detect a load edge as load==1 while a registered copy load_d==0; load_d updates every cycle.
REQ-014 SHALL make all outputs registered; effects of an edge or mode change appear on outputs the cycle after the triggering input is sampled.
REQ-015 S_P, load edge: P<=sw; go to S_Q; valid stays 0.
REQ-016 S_Q, load edge: Q<=sw; valid<=1; go to S_HOLD.
REQ-017 S_HOLD, load edge: P<=sw; valid<=0; go to S_Q; Q holds its old value until reloaded.
REQ-018 In S_P, S_Q and S_HOLD, with no load edge and sweep==0: P, Q, valid and state SHALL hold.
REQ-019 In S_P, S_Q or S_HOLD with sweep==1: P<=0, Q<=0, divider<=0, valid<=1, go to S_SWEEP; sweep takes priority over a same-cycle load edge, which is discarded.
REQ-020 S_SWEEP: a divider counts 0..STEP_DIV-1 and wraps; each cycle it equals STEP_DIV-1, the 10-bit value {P,Q} (Q is the low 5 bits) increments by 1.
REQ-021 When {P,Q}==10'h3FF at a step, {P,Q} wraps to 0 and done is 1 in that same update cycle only.
REQ-022 With STEP_DIV==1, {P,Q} SHALL step every cycle.
REQ-023 S_SWEEP: load edges ignored; valid stays 1.
REQ-024 S_SWEEP with sweep==0: go to S_P; valid<=0; divider<=0; P and Q keep their last values; no step occurs that cycle.
REQ-025 done SHALL be 0 in every state other than the wrap cycle in REQ-021.
REQ-026 Divider width SHALL be 16 bits; P/Q arithmetic is modulo 2^10, never saturating.

Reset
REQ-027 On rst==1 at a clock edge: P=0, Q=0, valid=0, done=0, state=S_P, divider=0, load_d=1.
REQ-028 load_d resets to 1, so load already high when rst releases does not count as an edge; a fresh 0->1 is required.
REQ-029 rst SHALL override all inputs, including mid-sweep and mid-load, and take effect at the next clock edge.

Verification
REQ-030 Manual load: rst, then sw=5'd12 with a load pulse, then sw=5'd7 with a load pulse -> P=12, valid=0 after the first pulse; Q=7, valid=1, state=2 after the second.
REQ-031 Reload from hold: in S_HOLD with P=12, Q=7, sw=5'd20 with a load pulse -> P=20, Q=7, valid=0, state=1; load held high for 10 cycles produces exactly one load.
REQ-032 Sweep, STEP_DIV=4: sweep=1 -> P=0, Q=0, valid=1, state=3; {P,Q} advances by 1 every 4 cycles; after 1024*4 cycles it equals 0 and done has pulsed exactly once.
REQ-033 Sweep exit: drop sweep at {P,Q}=10'h025 -> state=0, valid=0, P=1, Q=5 held; a load in the same cycle as sweep=1 is ignored.
REQ-034 Reset corners: rst asserted mid-sweep -> all outputs as in REQ-027 next cycle; load held high across rst release -> P unchanged, state=0.
REQ-035 Protocol check: for every test, valid==1 implies P and Q are stable between steps, and done is never high for 2 consecutive cycles.
